// File: rtl/audio_out_stage_if.sv
// Sample and control bundle between the sound mixer and the output stage.
interface audio_out_stage_if #(
    parameter int unsigned IN_W = 16
);
    logic                   in_ce;
    logic signed [IN_W-1:0] in_sample;
    logic [3:0]             gain;
    logic                   mute;
    logic signed [IN_W-1:0] out_sample;
    logic                   out_strobe;
    logic                   clip;

    modport master (
        output in_ce, in_sample, gain, mute,
        input  out_sample, out_strobe, clip
    );

    modport slave (
        input  in_ce, in_sample, gain, mute,
        output out_sample, out_strobe, clip
    );
endinterface

// File: rtl/audio_out_stage.sv
// Post-mix output stage: block-average decimation, 1-pole low-pass,
// master gain with saturation and mute, held output with strobe.
module audio_out_stage #(
    parameter int unsigned IN_W      = 16,
    parameter int unsigned AVG_LOG2  = 3,
    parameter int unsigned LPF_SHIFT = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    audio_out_stage_if.slave  bus
);
    localparam int unsigned ACC_W = IN_W + AVG_LOG2;
    localparam int unsigned P_W   = IN_W + 5;
    localparam logic [AVG_LOG2-1:0]   CNT_MAX = '1;
    localparam logic signed [P_W-1:0] Q_MAX   = {{6{1'b0}}, {(IN_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] Q_MIN   = {{6{1'b1}}, {(IN_W-1){1'b0}}};
    localparam logic signed [IN_W-1:0] OUT_MAX = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] OUT_MIN = {1'b1, {(IN_W-1){1'b0}}};

    logic [AVG_LOG2-1:0]    cnt_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [IN_W-1:0] avg_q;
    logic                   v1_q;
    logic signed [IN_W-1:0] y_q;
    logic                   v2_q;
    logic signed [IN_W-1:0] out_q;
    logic                   strobe_q;
    logic                   clip_q;

    logic signed [ACC_W-1:0] sum_c;
    logic signed [IN_W-1:0]  avg_d;
    logic signed [IN_W:0]    diff_c;
    logic signed [IN_W-1:0]  y_d;
    logic signed [P_W-1:0]   y_ext_c;
    logic signed [P_W-1:0]   g_ext_c;
    logic signed [P_W-1:0]   prod_c;
    logic signed [P_W-1:0]   q_c;
    logic signed [IN_W-1:0]  out_d;
    logic                    clip_d;

    // The wrap sample is included in the block sum before the floor divide.
    assign sum_c = acc_q + {{AVG_LOG2{bus.in_sample[IN_W-1]}}, bus.in_sample};
    assign avg_d = IN_W'(sum_c >>> AVG_LOG2);

    // Convex step toward avg, so y never leaves the IN_W range.
    assign diff_c = {avg_q[IN_W-1], avg_q} - {y_q[IN_W-1], y_q};
    assign y_d    = y_q + IN_W'(diff_c >>> LPF_SHIFT);

    assign y_ext_c = {{5{y_q[IN_W-1]}}, y_q};
    assign g_ext_c = {{(P_W-4){1'b0}}, bus.gain};
    assign prod_c  = y_ext_c * g_ext_c;
    assign q_c     = prod_c >>> 2;

    always_comb begin
        out_d  = q_c[IN_W-1:0];
        clip_d = 1'b0;
        if (q_c > Q_MAX) begin
            out_d  = OUT_MAX;
            clip_d = 1'b1;
        end else if (q_c < Q_MIN) begin
            out_d  = OUT_MIN;
            clip_d = 1'b1;
        end
        if (bus.mute) begin
            out_d  = '0;
            clip_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            avg_q    <= '0;
            v1_q     <= 1'b0;
            y_q      <= '0;
            v2_q     <= 1'b0;
            out_q    <= '0;
            strobe_q <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            v1_q <= 1'b0;
            if (bus.in_ce) begin
                if (cnt_q == CNT_MAX) begin
                    avg_q <= avg_d;
                    acc_q <= '0;
                    cnt_q <= '0;
                    v1_q  <= 1'b1;
                end else begin
                    acc_q <= sum_c;
                    cnt_q <= cnt_q + AVG_LOG2'(1);
                end
            end

            v2_q <= v1_q;
            if (v1_q) begin
                y_q <= y_d;
            end

            strobe_q <= v2_q;
            clip_q   <= 1'b0;
            if (v2_q) begin
                out_q  <= out_d;
                clip_q <= clip_d;
            end
        end
    end

    assign bus.out_sample = out_q;
    assign bus.out_strobe = strobe_q;
    assign bus.clip       = clip_q;
endmodule

// File: tb/tb_audio_out_stage.sv
// Directed bench for audio_out_stage: filtered instance (LPF_SHIFT=2) and bypass instance (LPF_SHIFT=0).
module tb_audio_out_stage;
    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic               reset;
    logic               in_ce;
    logic signed [15:0] in_sample;
    logic [3:0]         gain;
    logic               mute;

    int err_cnt = 0;
    int chk_cnt = 0;

    audio_out_stage_if #(.IN_W(16)) bus0 ();
    audio_out_stage_if #(.IN_W(16)) bus1 ();

    assign bus0.in_ce     = in_ce;
    assign bus0.in_sample = in_sample;
    assign bus0.gain      = gain;
    assign bus0.mute      = mute;
    assign bus1.in_ce     = in_ce;
    assign bus1.in_sample = in_sample;
    assign bus1.gain      = gain;
    assign bus1.mute      = mute;

    audio_out_stage #(.IN_W(16), .AVG_LOG2(3), .LPF_SHIFT(2)) u_dut0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus0.slave)
    );

    audio_out_stage #(.IN_W(16), .AVG_LOG2(3), .LPF_SHIFT(0)) u_dut1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus1.slave)
    );

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_ce = 1'b0;
        tick();
        tick();
    endtask

    // Wait (bounded) for the next strobe of the selected instance.
    task automatic next_strobe(input int sel, output int o, output int c);
        bit seen;
        seen = 1'b0;
        o = 0;
        c = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (sel == 0 ? bus0.out_strobe : bus1.out_strobe) begin
                seen = 1'b1;
                o = sel == 0 ? int'(bus0.out_sample) : int'(bus1.out_sample);
                c = sel == 0 ? int'(bus0.clip) : int'(bus1.clip);
            end
        end
        check("strobe_seen", int'(seen), 1);
    endtask

    int o, c;
    int exp1 [4] = '{250, 437, 577, 682};

    initial begin
        reset = 1'b1; in_ce = 1'b0; in_sample = '0; gain = 4'd4; mute = 1'b0;
        tick(); tick();
        check("rst_out", int'(bus0.out_sample), 0);
        check("rst_strobe", int'(bus0.out_strobe), 0);
        check("rst_clip", int'(bus0.clip), 0);

        // Constant 1000, unity gain: filter step response.
        in_sample = 16'sd1000; in_ce = 1'b1; reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_strobe(0, o, c);
            check("s1_out", o, exp1[k]);
            check("s1_clip", c, 0);
            if (k == 0) begin
                tick();
                check("s1_pulse", int'(bus0.out_strobe), 0);
                check("s1_hold", int'(bus0.out_sample), 250);
            end
        end

        // -1 constant through the bypass instance: floor keeps -1.
        do_reset();
        in_sample = -16'sd1; in_ce = 1'b1; reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            next_strobe(1, o, c);
            check("s2_out", o, -1);
        end

        // Block average floors: 1..8 -> 4, -1..-8 -> -5.
        for (int s = 0; s < 2; s++) begin
            do_reset();
            reset = 1'b0;
            for (int i = 0; i < 8; i++) begin
                in_ce = 1'b1;
                in_sample = 16'(s == 0 ? i + 1 : -(i + 1));
                tick();
            end
            in_ce = 1'b0;
            next_strobe(1, o, c);
            check("avg_floor", o, s == 0 ? 4 : -5);
        end

        // Positive full scale at gain 15.
        do_reset();
        gain = 4'd15; in_sample = 16'sd32767; in_ce = 1'b1; reset = 1'b0;
        next_strobe(0, o, c);
        check("s3_out0", o, 30716);
        check("s3_clip0", c, 0);
        next_strobe(0, o, c);
        check("s3_out1", o, 32767);
        check("s3_clip1", c, 1);
        tick();
        check("s3_clip_pulse", int'(bus0.clip), 0);
        next_strobe(0, o, c);
        check("s3_out2", o, 32767);
        check("s3_clip2", c, 1);

        // Negative full scale at gain 15.
        do_reset();
        in_sample = -16'sd32768; in_ce = 1'b1; reset = 1'b0;
        next_strobe(0, o, c);
        check("s4_out0", o, -30720);
        check("s4_clip0", c, 0);
        next_strobe(0, o, c);
        check("s4_out1", o, -32768);
        check("s4_clip1", c, 1);

        // Gain 0 never clips.
        do_reset();
        gain = 4'd0; in_sample = 16'sd32767; in_ce = 1'b1; reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            next_strobe(0, o, c);
            check("g0_out", o, 0);
            check("g0_clip", c, 0);
        end

        // Mute for 4 strobes; filter keeps running underneath.
        do_reset();
        gain = 4'd4; mute = 1'b1; in_sample = 16'sd1000; in_ce = 1'b1; reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            next_strobe(0, o, c);
            check("s5_mute_out", o, 0);
            check("s5_mute_clip", c, 0);
        end
        mute = 1'b0;
        next_strobe(0, o, c);
        check("s5_unmute", o, 761);

        // Partial block, 1-cycle reset (with ce high), then fresh block of 800.
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_ce = 1'b1; in_sample = 16'sd5000;
            tick();
            in_ce = 1'b0;
            tick();
        end
        reset = 1'b1; in_ce = 1'b1; in_sample = 16'sd5000;
        tick();
        reset = 1'b0; in_sample = 16'sd800;
        for (int i = 0; i < 8; i++) tick();
        in_ce = 1'b0;
        check("s6_lat1", int'(bus0.out_strobe), 0);
        tick();
        check("s6_lat2", int'(bus0.out_strobe), 0);
        tick();
        check("s6_lat3", int'(bus0.out_strobe), 1);
        check("s6_out", int'(bus0.out_sample), 200);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
